// File: rtl/if_fetch_stage.sv
// Purpose: instruction-fetch stage + IF/ID register of the 32-bit mini-MIPS pipeline; owns the PC.
// Latency: one cycle from imem_ack to IF/ID; zero-wait memory sustains one instruction per cycle.
// Backpressure: pcw_control/if_id_reg_control stall the stage; a word acked under stall parks in a hold buffer.
//
// Ports:
//   clk, reset_n                 rising-edge clock, asynchronous active-low reset
//   pcw_control                  1 = PC may advance
//   if_id_reg_control            1 = IF/ID may load
//   pc_src, branch_target        taken-branch redirect (target bits [1:0] forced to 00)
//   imem_req/imem_addr           fetch request and word address
//   imem_ack/imem_rdata          fetch response
//   if_id_inst/if_id_pc4/if_id_valid  IF/ID register contents to decode
//   fetch_busy                   1 whenever the stage is not in REQ
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pcw_control,
  input  logic        if_id_reg_control,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic [31:0] drain_addr, drain_addr_nxt;
  logic [31:0] hold_inst, hold_inst_nxt;
  logic [31:0] hold_pc4, hold_pc4_nxt;
  logic [31:0] inst_nxt, pc4_nxt;
  logic        valid_nxt;
  logic        advance;
  logic        fetch_load;
  logic        unused_bt;

  assign advance     = pcw_control & if_id_reg_control;
  assign pc_plus4    = pc + 32'd4;  // wraps modulo 2^32
  assign redirect_pc = {branch_target[31:2], 2'b00};
  assign unused_bt   = ^branch_target[1:0];

  assign imem_req   = (state == S_REQ) || (state == S_DRAIN);
  // While draining, the PC already points at the redirect target, so the
  // outstanding request's address is replayed from drain_addr to keep it stable.
  assign imem_addr  = (state == S_DRAIN) ? drain_addr : pc;
  assign fetch_busy = (state != S_REQ);

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drain_addr_nxt = drain_addr;
    hold_inst_nxt  = hold_inst;
    hold_pc4_nxt   = hold_pc4;
    inst_nxt       = if_id_inst;
    pc4_nxt        = if_id_pc4;
    valid_nxt      = if_id_valid;
    fetch_load     = 1'b0;

    if (pc_src) begin
      // Redirect beats stalls and any response arriving this cycle.
      inst_nxt      = NOP_INST;
      valid_nxt     = 1'b0;
      pc_nxt        = redirect_pc;
      hold_inst_nxt = 32'h0;
      hold_pc4_nxt  = 32'h0;
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            state_nxt = S_REQ;
          end else begin
            // Request still in flight: remember its address and drain it.
            state_nxt      = S_DRAIN;
            drain_addr_nxt = pc;
          end
        end
        S_DRAIN: state_nxt = S_DRAIN;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE: state_nxt = S_REQ;
        S_REQ: begin
          if (!imem_ack) begin
            if (if_id_reg_control) begin
              inst_nxt  = NOP_INST;
              valid_nxt = 1'b0;
            end
          end else if (advance) begin
            inst_nxt   = imem_rdata;
            pc4_nxt    = pc_plus4;
            valid_nxt  = 1'b1;
            pc_nxt     = pc_plus4;
            fetch_load = 1'b1;
          end else begin
            hold_inst_nxt = imem_rdata;
            hold_pc4_nxt  = pc_plus4;
            state_nxt     = S_HOLD;
            if (if_id_reg_control) begin
              inst_nxt  = NOP_INST;
              valid_nxt = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (advance) begin
            inst_nxt   = hold_inst;
            pc4_nxt    = hold_pc4;
            valid_nxt  = 1'b1;
            pc_nxt     = pc_plus4;
            fetch_load = 1'b1;
            state_nxt  = S_REQ;
          end
        end
        default: begin  // S_DRAIN: response is for a squashed fetch
          if (if_id_reg_control) begin
            inst_nxt  = NOP_INST;
            valid_nxt = 1'b0;
          end
          if (imem_ack) state_nxt = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      drain_addr  <= 32'h0;
      hold_inst   <= 32'h0;
      hold_pc4    <= 32'h0;
      if_id_inst  <= NOP_INST;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drain_addr  <= drain_addr_nxt;
      hold_inst   <= hold_inst_nxt;
      hold_pc4    <= hold_pc4_nxt;
      if_id_inst  <= inst_nxt;
      if_id_pc4   <= pc4_nxt;
      if_id_valid <= valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic stall_cycle;
  assign stall_cycle = (state != S_IDLE) && !advance && !pc_src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (fetch_load)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_cycle) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage. Each table row is one clock
// cycle: the inputs driven during that cycle and the outputs expected to be
// visible during it (they reflect the state left by the previous edge).
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h1111_0000;
  localparam logic [31:0] BAD = 32'hBAD0_0000;

  logic        clk;
  logic        reset_n;
  logic        pcw_control;
  logic        if_id_reg_control;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_busy;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pcw_control       (pcw_control),
    .if_id_reg_control (if_id_reg_control),
    .pc_src            (pc_src),
    .branch_target     (branch_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .if_id_inst        (if_id_inst),
    .if_id_pc4         (if_id_pc4),
    .if_id_valid       (if_id_valid),
    .fetch_busy        (fetch_busy)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcw;
    logic        ifr;
    logic        src;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        chk_pc4;
    logic        e_valid;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic pcw, input logic ifr, input logic src,
                     input logic [31:0] tgt, input logic ack, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic [31:0] e_inst, input logic [31:0] e_pc4,
                     input logic chk_pc4, input logic e_valid, input logic e_busy);
    vec_t v;
    v.pcw = pcw; v.ifr = ifr; v.src = src; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_inst = e_inst; v.e_pc4 = e_pc4;
    v.chk_pc4 = chk_pc4; v.e_valid = e_valid; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic [31:0] e_inst, input logic [31:0] e_pc4,
                          input logic chk_pc4, input logic e_valid, input logic e_busy);
    n_vec++;
    chk({tag, " imem_req"},    {31'b0, imem_req},    {31'b0, e_req});
    chk({tag, " imem_addr"},   imem_addr,            e_addr);
    chk({tag, " if_id_inst"},  if_id_inst,           e_inst);
    if (chk_pc4) chk({tag, " if_id_pc4"}, if_id_pc4, e_pc4);
    chk({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
    chk({tag, " fetch_busy"},  {31'b0, fetch_busy},  {31'b0, e_busy});
  endtask

  initial begin
    //  pcw ifr src tgt           ack rdata          req addr          inst          pc4           c4 v  busy
    add(1, 1, 0, 32'h0,          1, BAD,           0, 32'h0,         NOP,          32'h0,        1, 0, 1); // IDLE, ack ignored
    add(1, 1, 0, 32'h0,          1, 32'hC000_0000, 1, 32'h0,         NOP,          32'h0,        1, 0, 0);
    add(1, 1, 0, 32'h0,          1, 32'hC000_0004, 1, 32'h4,         32'hC000_0000, 32'h4,       1, 1, 0);
    add(1, 1, 0, 32'h0,          1, 32'hC000_0008, 1, 32'h8,         32'hC000_0004, 32'h8,       1, 1, 0);
    add(1, 1, 0, 32'h0,          0, BAD,           1, 32'hC,         32'hC000_0008, 32'hC,       1, 1, 0); // ack delayed
    add(1, 1, 0, 32'h0,          0, BAD,           1, 32'hC,         NOP,          32'h0,        0, 0, 0);
    add(1, 1, 0, 32'h0,          1, 32'hC000_000C, 1, 32'hC,         NOP,          32'h0,        0, 0, 0);
    add(0, 0, 0, 32'h0,          1, 32'hC000_0010, 1, 32'h10,        32'hC000_000C, 32'h10,      1, 1, 0); // ack under stall
    add(0, 0, 0, 32'h0,          1, BAD,           0, 32'h10,        32'hC000_000C, 32'h10,      1, 1, 1); // HOLD
    add(1, 1, 0, 32'h0,          0, BAD,           0, 32'h10,        32'hC000_000C, 32'h10,      1, 1, 1); // release
    add(1, 1, 0, 32'h0,          1, 32'hC000_0014, 1, 32'h14,        32'hC000_0010, 32'h14,      1, 1, 0);
    add(1, 1, 0, 32'h0,          1, 32'hC000_0018, 1, 32'h18,        32'hC000_0014, 32'h18,      1, 1, 0);
    add(1, 1, 0, 32'h0,          1, 32'hC000_001C, 1, 32'h1C,        32'hC000_0018, 32'h1C,      1, 1, 0);
    add(1, 1, 0, 32'h0,          0, BAD,           1, 32'h20,        32'hC000_001C, 32'h20,      1, 1, 0);
    add(1, 1, 1, 32'h40,         0, BAD,           1, 32'h20,        NOP,          32'h0,        0, 0, 0); // redirect, 0x20 pending
    add(1, 1, 0, 32'h0,          0, BAD,           1, 32'h20,        NOP,          32'h0,        0, 0, 1); // DRAIN
    add(1, 1, 0, 32'h0,          1, 32'hC000_0020, 1, 32'h20,        NOP,          32'h0,        0, 0, 1); // discarded
    add(1, 1, 0, 32'h0,          1, 32'hC000_0040, 1, 32'h40,        NOP,          32'h0,        0, 0, 0);
    add(0, 1, 1, 32'h40,         1, 32'hC000_0044, 1, 32'h44,        32'hC000_0040, 32'h44,      1, 1, 0); // redirect + ack + stall
    add(1, 0, 1, 32'h43,         1, 32'hC000_0040, 1, 32'h40,        NOP,          32'h0,        0, 0, 0); // unaligned target
    add(1, 1, 0, 32'h0,          1, 32'hC000_0040, 1, 32'h40,        NOP,          32'h0,        0, 0, 0);
    add(1, 1, 1, 32'hFFFF_FFFC,  1, 32'hC000_0044, 1, 32'h44,        32'hC000_0040, 32'h44,      1, 1, 0);
    add(1, 1, 0, 32'h0,          1, 32'h7777_0000, 1, 32'hFFFF_FFFC, NOP,          32'h0,        0, 0, 0);
    add(1, 1, 0, 32'h0,          1, 32'hC000_0000, 1, 32'h0,         32'h7777_0000, 32'h0,       1, 1, 0); // pc4 wrapped
    add(1, 0, 0, 32'h0,          0, BAD,           1, 32'h4,         32'hC000_0000, 32'h4,       1, 1, 0); // IF/ID hold
    add(1, 0, 0, 32'h0,          1, 32'hC000_0004, 1, 32'h4,         32'hC000_0000, 32'h4,       1, 1, 0); // ack, IF/ID stalled
    add(0, 1, 1, 32'h80,         1, BAD,           0, 32'h4,         32'hC000_0000, 32'h4,       1, 1, 1); // redirect from HOLD
    add(1, 1, 0, 32'h0,          1, 32'hC000_0080, 1, 32'h80,        NOP,          32'h0,        0, 0, 0);
    add(1, 1, 0, 32'h0,          0, BAD,           1, 32'h84,        32'hC000_0080, 32'h84,      1, 1, 0);

    reset_n = 1'b0; pcw_control = 1'b1; if_id_reg_control = 1'b1; pc_src = 1'b0;
    branch_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1 chk_outs("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      pcw_control = vecs[i].pcw; if_id_reg_control = vecs[i].ifr; pc_src = vecs[i].src;
      branch_target = vecs[i].tgt; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      #1 chk_outs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_inst,
                  vecs[i].e_pc4, vecs[i].chk_pc4, vecs[i].e_valid, vecs[i].e_busy);
      @(negedge clk);
    end

    // Reset while a request to 0x84 is outstanding: request is abandoned.
    pcw_control = 1'b1; if_id_reg_control = 1'b1; pc_src = 1'b0; imem_ack = 1'b0;
    reset_n = 1'b0;
    #1 chk_outs("midreset", 1'b0, 32'h0, NOP, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk_outs("rel_idle", 1'b0, 32'h0, NOP, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #1 chk_outs("rel_req", 1'b1, 32'h0, NOP, 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef IF_PERF_CNT_EN
    // Fresh start: 5 fetches then 3 stall cycles in REQ.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; imem_ack = 1'b0; pcw_control = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      imem_ack = 1'b1; imem_rdata = 32'hC000_0000 + 32'(k * 4);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      imem_ack = 1'b0; pcw_control = 1'b0;
    end
    @(negedge clk);
    pcw_control = 1'b1;
    #1;
    n_vec++;
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'd5);
    chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
    reset_n = 1'b0;
    #1;
    n_vec++;
    chk("perf_fetch_cnt reset", perf_fetch_cnt, 32'd0);
    chk("perf_stall_cnt reset", perf_stall_cnt, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
